// File: rtl/de_pipe_stage_if.sv
//------------------------------------------------------------------------------
// de_pipe_stage_if : decode->execute stage bus (decode side = master).
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface de_pipe_stage_if #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int CTRL_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int FLUSH_W = 2
);
  logic               in_valid;
  logic               stall;
  logic               flush_req;
  logic [FLUSH_W-1:0] flush_num;
  logic               imm_req;
  logic [CTRL_W-1:0]  ctrl_in;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  rs_data;
  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  rs_addr;
  logic [INSTR_W-1:0] instr_in;
`ifdef DE_FWD_EN
  logic               wb_we;
  logic [ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;
`endif
  logic               out_valid;
  logic [CTRL_W-1:0]  ctrl_out;
  logic [DATA_W-1:0]  rd_out;
  logic [DATA_W-1:0]  rs_out;
  logic [ADDR_W-1:0]  rd_addr_out;
  logic [ADDR_W-1:0]  rs_addr_out;
  logic [INSTR_W-1:0] imm_out;
  logic [INSTR_W-1:0] instr_out;
  logic               imm_pending;
  logic               flushing;

  modport master (
    output in_valid, stall, flush_req, flush_num, imm_req, ctrl_in,
           rd_data, rs_data, rd_addr, rs_addr, instr_in,
`ifdef DE_FWD_EN
           wb_we, wb_addr, wb_data,
`endif
    input  out_valid, ctrl_out, rd_out, rs_out, rd_addr_out, rs_addr_out,
           imm_out, instr_out, imm_pending, flushing
  );

  modport slave (
    input  in_valid, stall, flush_req, flush_num, imm_req, ctrl_in,
           rd_data, rs_data, rd_addr, rs_addr, instr_in,
`ifdef DE_FWD_EN
           wb_we, wb_addr, wb_data,
`endif
    output out_valid, ctrl_out, rd_out, rs_out, rd_addr_out, rs_addr_out,
           imm_out, instr_out, imm_pending, flushing
  );
endinterface

`default_nettype wire

// File: rtl/de_pipe_stage.sv
//------------------------------------------------------------------------------
// de_pipe_stage : decode->execute pipeline register with stall, flush counter
//                 and two-word (header + immediate) instruction merging.
//                 Optional write-back bypass enabled by defining DE_FWD_EN.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module de_pipe_stage #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int CTRL_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int FLUSH_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  de_pipe_stage_if.slave bus
);

  typedef enum logic [0:0] {
    NORMAL   = 1'b0,
    WAIT_IMM = 1'b1
  } state_e;

  localparam logic [FLUSH_W-1:0] CNT_ONE = FLUSH_W'(1);

  state_e             state_q, state_d;
  logic [FLUSH_W-1:0] cnt_q, cnt_d;

  // Header word held while the immediate word is awaited
  logic [CTRL_W-1:0]  hdr_ctrl_q, hdr_ctrl_d;
  logic [DATA_W-1:0]  hdr_rd_q, hdr_rd_d;
  logic [DATA_W-1:0]  hdr_rs_q, hdr_rs_d;
  logic [ADDR_W-1:0]  hdr_rd_addr_q, hdr_rd_addr_d;
  logic [ADDR_W-1:0]  hdr_rs_addr_q, hdr_rs_addr_d;
  logic [INSTR_W-1:0] hdr_instr_q, hdr_instr_d;

  logic               valid_q, valid_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [DATA_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  rs_q, rs_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  rs_addr_q, rs_addr_d;
  logic [INSTR_W-1:0] imm_q, imm_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Operand values after optional write-back bypass
  logic [DATA_W-1:0]  w_rd_op, w_rs_op, w_hdr_rd_op, w_hdr_rs_op;

`ifdef DE_FWD_EN
  function automatic logic [DATA_W-1:0] byp(
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] d
  );
    return (we && (wa == a)) ? wd : d;
  endfunction

  assign w_rd_op     = byp(bus.wb_we, bus.wb_addr, bus.wb_data, bus.rd_addr, bus.rd_data);
  assign w_rs_op     = byp(bus.wb_we, bus.wb_addr, bus.wb_data, bus.rs_addr, bus.rs_data);
  assign w_hdr_rd_op = byp(bus.wb_we, bus.wb_addr, bus.wb_data, hdr_rd_addr_q, hdr_rd_q);
  assign w_hdr_rs_op = byp(bus.wb_we, bus.wb_addr, bus.wb_data, hdr_rs_addr_q, hdr_rs_q);
`else
  assign w_rd_op     = bus.rd_data;
  assign w_rs_op     = bus.rs_data;
  assign w_hdr_rd_op = hdr_rd_q;
  assign w_hdr_rs_op = hdr_rs_q;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hdr_ctrl_d    = hdr_ctrl_q;
    hdr_rd_d      = hdr_rd_q;
    hdr_rs_d      = hdr_rs_q;
    hdr_rd_addr_d = hdr_rd_addr_q;
    hdr_rs_addr_d = hdr_rs_addr_q;
    hdr_instr_d   = hdr_instr_q;
    valid_d       = valid_q;
    ctrl_d        = ctrl_q;
    rd_d          = rd_q;
    rs_d          = rs_q;
    rd_addr_d     = rd_addr_q;
    rs_addr_d     = rs_addr_q;
    imm_d         = imm_q;
    instr_d       = instr_q;

    if (bus.flush_req) begin
      // Squash wins over stall: the presented word and any held header die here
      valid_d = 1'b0;
      ctrl_d  = '0;
      state_d = NORMAL;
      cnt_d   = bus.flush_num;
    end else if (!bus.stall) begin
      if (state_q == WAIT_IMM) begin
        hdr_rd_d = w_hdr_rd_op;
        hdr_rs_d = w_hdr_rs_op;
      end
      if (!bus.in_valid) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (cnt_q != '0) begin
        cnt_d   = cnt_q - CNT_ONE;
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (state_q == NORMAL) begin
        if (bus.imm_req) begin
          hdr_ctrl_d    = bus.ctrl_in;
          hdr_rd_d      = w_rd_op;
          hdr_rs_d      = w_rs_op;
          hdr_rd_addr_d = bus.rd_addr;
          hdr_rs_addr_d = bus.rs_addr;
          hdr_instr_d   = bus.instr_in;
          valid_d       = 1'b0;
          ctrl_d        = '0;
          state_d       = WAIT_IMM;
        end else begin
          valid_d   = 1'b1;
          ctrl_d    = bus.ctrl_in;
          rd_d      = w_rd_op;
          rs_d      = w_rs_op;
          rd_addr_d = bus.rd_addr;
          rs_addr_d = bus.rs_addr;
          imm_d     = '0;
          instr_d   = bus.instr_in;
        end
      end else begin
        valid_d   = 1'b1;
        ctrl_d    = hdr_ctrl_q;
        rd_d      = w_hdr_rd_op;
        rs_d      = w_hdr_rs_op;
        rd_addr_d = hdr_rd_addr_q;
        rs_addr_d = hdr_rs_addr_q;
        imm_d     = bus.instr_in;
        instr_d   = hdr_instr_q;
        state_d   = NORMAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NORMAL;
      cnt_q         <= '0;
      hdr_ctrl_q    <= '0;
      hdr_rd_q      <= '0;
      hdr_rs_q      <= '0;
      hdr_rd_addr_q <= '0;
      hdr_rs_addr_q <= '0;
      hdr_instr_q   <= '0;
      valid_q       <= 1'b0;
      ctrl_q        <= '0;
      rd_q          <= '0;
      rs_q          <= '0;
      rd_addr_q     <= '0;
      rs_addr_q     <= '0;
      imm_q         <= '0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hdr_ctrl_q    <= hdr_ctrl_d;
      hdr_rd_q      <= hdr_rd_d;
      hdr_rs_q      <= hdr_rs_d;
      hdr_rd_addr_q <= hdr_rd_addr_d;
      hdr_rs_addr_q <= hdr_rs_addr_d;
      hdr_instr_q   <= hdr_instr_d;
      valid_q       <= valid_d;
      ctrl_q        <= ctrl_d;
      rd_q          <= rd_d;
      rs_q          <= rs_d;
      rd_addr_q     <= rd_addr_d;
      rs_addr_q     <= rs_addr_d;
      imm_q         <= imm_d;
      instr_q       <= instr_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.ctrl_out    = ctrl_q;
  assign bus.rd_out      = rd_q;
  assign bus.rs_out      = rs_q;
  assign bus.rd_addr_out = rd_addr_q;
  assign bus.rs_addr_out = rs_addr_q;
  assign bus.imm_out     = imm_q;
  assign bus.instr_out   = instr_q;
  assign bus.imm_pending = (state_q == WAIT_IMM);
  assign bus.flushing    = (cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_de_pipe_stage.sv
//------------------------------------------------------------------------------
// tb_de_pipe_stage : directed vector table plus hand sequences for de_pipe_stage.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_de_pipe_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  de_pipe_stage_if bus ();

  de_pipe_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst, iv, st, fr;
    logic [1:0]  fn;
    logic        ir;
    logic [15:0] ctrl, rd, instr;
    logic        e_ov;
    logic [15:0] e_ctrl, e_rd, e_imm, e_instr;
    logic        e_pend, e_fl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, iv, st, fr, input logic [1:0] fn, input logic ir,
    input logic [15:0] ctrl, rd, instr,
    input logic ov, input logic [15:0] ectrl, erd, eimm, einstr,
    input logic pend, fl);
    vec_t v;
    v.rst = rst; v.iv = iv; v.st = st; v.fr = fr; v.fn = fn; v.ir = ir;
    v.ctrl = ctrl; v.rd = rd; v.instr = instr;
    v.e_ov = ov; v.e_ctrl = ectrl; v.e_rd = erd; v.e_imm = eimm;
    v.e_instr = einstr; v.e_pend = pend; v.e_fl = fl;
    return v;
  endfunction

  function automatic logic [15:0] swap(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // rs operand is the byte-swapped rd operand; addresses come from rd bits
  task automatic drive(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    bus.in_valid  = v.iv;
    bus.stall     = v.st;
    bus.flush_req = v.fr;
    bus.flush_num = v.fn;
    bus.imm_req   = v.ir;
    bus.ctrl_in   = v.ctrl;
    bus.rd_data   = v.rd;
    bus.rs_data   = swap(v.rd);
    bus.rd_addr   = v.rd[2:0];
    bus.rs_addr   = v.rd[5:3];
    bus.instr_in  = v.instr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] snap();
    return 128'({bus.out_valid, bus.ctrl_out, bus.rd_out, bus.rs_out, bus.rd_addr_out,
                 bus.rs_addr_out, bus.imm_out, bus.instr_out, bus.imm_pending, bus.flushing});
  endfunction

  function automatic logic [127:0] expect_of(input vec_t v);
    return 128'({v.e_ov, v.e_ctrl, v.e_rd, swap(v.e_rd), v.e_rd[2:0], v.e_rd[5:3],
                 v.e_imm, v.e_instr, v.e_pend, v.e_fl});
  endfunction

  initial begin
    vec_t v;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush_req = 1'b0; bus.flush_num = '0;
    bus.imm_req = 1'b0; bus.ctrl_in = '0; bus.rd_data = '0; bus.rs_data = '0;
    bus.rd_addr = '0; bus.rs_addr = '0; bus.instr_in = '0;
`ifdef DE_FWD_EN
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
`endif

    //                rst iv st fr fn ir ctrl      rd        instr      ov ctrl      rd        imm       instr     pd fl
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0021, 16'h1234, 16'h1111,  1, 16'h0021, 16'h1234, 16'h0000, 16'h1111, 0, 0)); // one-word
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'hFFFF, 16'hEEEE, 16'hEEEE,  0, 16'h0000, 16'h1234, 16'h0000, 16'h1111, 0, 0)); // bubble
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16'h0042, 16'hAAAA, 16'hC300,  0, 16'h0000, 16'h1234, 16'h0000, 16'h1111, 1, 0)); // header
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16'hFFFF, 16'h5555, 16'h00FF,  1, 16'h0042, 16'hAAAA, 16'h00FF, 16'hC300, 0, 0)); // immediate
    vecs.push_back(mk(0, 1, 0, 1, 2, 0, 16'h0077, 16'h7777, 16'h7777,  0, 16'h0000, 16'hAAAA, 16'h00FF, 16'hC300, 0, 1)); // flush 2
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0078, 16'h7878, 16'h7878,  0, 16'h0000, 16'hAAAA, 16'h00FF, 16'hC300, 0, 1)); // dropped
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0079, 16'h7979, 16'h7979,  0, 16'h0000, 16'hAAAA, 16'h00FF, 16'hC300, 0, 0)); // dropped
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0088, 16'h8888, 16'h8888,  1, 16'h0088, 16'h8888, 16'h0000, 16'h8888, 0, 0)); // 4th passes
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0099, 16'h9999, 16'h9999,  1, 16'h0088, 16'h8888, 16'h0000, 16'h8888, 0, 0)); // stall
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 16'h009A, 16'h9A9A, 16'h9A9A,  1, 16'h0088, 16'h8888, 16'h0000, 16'h8888, 0, 0)); // stall
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'hABCD, 16'hABCD, 16'hABCD,  1, 16'h0088, 16'h8888, 16'h0000, 16'h8888, 0, 0)); // stall
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 16'h00BB, 16'hBBBB, 16'hBBBB,  0, 16'h0000, 16'h8888, 16'h0000, 16'h8888, 0, 0)); // flush in stall
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16'h0100, 16'h0101, 16'h9100,  0, 16'h0000, 16'h8888, 16'h0000, 16'h8888, 1, 0)); // header 9100
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 16'h0102, 16'h0102, 16'h0102,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0)); // reset mid-wait
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16'h0D00, 16'h0D0D, 16'hD000,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0)); // header
    vecs.push_back(mk(0, 1, 0, 1, 3, 0, 16'h0E00, 16'h0E0E, 16'h0E00,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1)); // flush 3, kills header
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0F00, 16'h0F0F, 16'h0F00,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1)); // idle: count holds
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 16'h1000, 16'h1010, 16'h1000,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1)); // reload 1
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h1100, 16'h1111, 16'h1100,  0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0)); // dropped
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0014, 16'h1414, 16'h1400,  1, 16'h0014, 16'h1414, 16'h0000, 16'h1400, 0, 0)); // one-word
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 16'h0050, 16'h5050, 16'h5000,  0, 16'h0000, 16'h1414, 16'h0000, 16'h1400, 1, 0)); // header
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0051, 16'h5151, 16'h0BAD,  0, 16'h0000, 16'h1414, 16'h0000, 16'h1400, 1, 0)); // stall in wait
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0052, 16'h5252, 16'h00AB,  1, 16'h0050, 16'h5050, 16'h00AB, 16'h5000, 0, 0)); // immediate
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 16'h0001, 16'h0001, 16'h0002,  1, 16'h0001, 16'h0001, 16'h0000, 16'h0002, 0, 0)); // imm cleared

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      chk($sformatf("vec%0d", i), snap(), expect_of(vecs[i]));
    end

    // Zero-length flush: bubble, no flushing, next word passes straight through
    v = mk(0, 1, 0, 1, 0, 0, 16'h0031, 16'h3131, 16'h3100, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    chk("flush0_valid", 128'(bus.out_valid), 128'(0));
    chk("flush0_flushing", 128'(bus.flushing), 128'(0));
    v = mk(0, 1, 0, 0, 0, 0, 16'h0033, 16'h3333, 16'h3300, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    chk("flush0_next_valid", 128'(bus.out_valid), 128'(1));
    chk("flush0_next_ctrl", 128'(bus.ctrl_out), 128'(16'h0033));

`ifdef DE_FWD_EN
    // Bypass at one-word capture: rs_addr=3 matches write-back
    @(negedge clk);
    bus.in_valid = 1'b1; bus.imm_req = 1'b0; bus.ctrl_in = 16'h0005;
    bus.rd_addr = 3'd1; bus.rd_data = 16'h1111; bus.rs_addr = 3'd3; bus.rs_data = 16'h0000;
    bus.instr_in = 16'h0500;
    bus.wb_we = 1'b1; bus.wb_addr = 3'd3; bus.wb_data = 16'hBEEF;
    @(posedge clk); #1;
    chk("fwd_rs", 128'(bus.rs_out), 128'(16'hBEEF));
    chk("fwd_rd_nomatch", 128'(bus.rd_out), 128'(16'h1111));
    // Bypass refreshes a held header operand while waiting for the immediate
    @(negedge clk);
    bus.imm_req = 1'b1; bus.rd_addr = 3'd2; bus.rd_data = 16'h2222; bus.rs_addr = 3'd4;
    bus.rs_data = 16'h4444; bus.instr_in = 16'hC200; bus.wb_we = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    bus.imm_req = 1'b0; bus.instr_in = 16'h0042;
    bus.wb_we = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'hCAFE;
    @(posedge clk); #1;
    chk("fwd_hdr_rd", 128'(bus.rd_out), 128'(16'hCAFE));
    chk("fwd_hdr_rs", 128'(bus.rs_out), 128'(16'h4444));
    bus.wb_we = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
